// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-stage state encoding, which doubles as occupancy.
package pipe_pkg;

   localparam int unsigned OCC_W = 2;

   localparam logic [OCC_W-1:0] ST_EMPTY = 2'd0;
   localparam logic [OCC_W-1:0] ST_ONE   = 2'd1;
   localparam logic [OCC_W-1:0] ST_FULL  = 2'd2;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule : sat_counter

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// flush and a saturating stall-cycle counter.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned N       = 32,
   parameter int unsigned STALL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0]       in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N-1:0]       out_data,
   output logic [OCC_W-1:0]   occupancy,
   input  logic               stall_clr,
   output logic [STALL_W-1:0] stall_count
);

   logic [OCC_W-1:0] state, state_nxt;
   logic [N-1:0]     main_q, main_nxt;
   logic [N-1:0]     skid_q, skid_nxt;
   logic             in_fire, out_fire;
   logic             stall_inc;

   // Handshake is a function of registered state and enable only.
   assign in_ready  = enable & (state != ST_FULL);
   assign out_valid = enable & (state != ST_EMPTY);
   assign out_data  = main_q;
   assign occupancy = state;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign stall_inc = (state != ST_EMPTY) & enable & ~out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
      end
   end

   // Next-state and data steering; flush squashes occupancy but leaves data alone.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_nxt  = in_data;
                  state_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_nxt = in_data;
               end else if (in_fire) begin
                  skid_nxt  = in_data;
                  state_nxt = ST_FULL;
               end else if (out_fire) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  main_nxt  = skid_q;
                  state_nxt = ST_ONE;
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   sat_counter #(
      .W (STALL_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst),
      .clr   (stall_clr),
      .inc   (stall_inc),
      .count (stall_count)
   );

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Table-driven bench for pipe_skid_reg with a data scoreboard; a second
// instance with a 2-bit stall counter shares the stimulus to check saturation.
module tb_pipe_skid_reg;

   localparam int unsigned N   = 32;
   localparam int unsigned SW  = 16;
   localparam int unsigned SW2 = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           enable;
   logic           flush;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   in_data;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   out_data;
   logic [1:0]     occupancy;
   logic           stall_clr;
   logic [SW-1:0]  stall_count;

   logic           in_ready2;
   logic           out_valid2;
   logic [N-1:0]   out_data2;
   logic [1:0]     occupancy2;
   logic [SW2-1:0] stall_count2;

   always #5 clk = ~clk;

   pipe_skid_reg #(.N(N), .STALL_W(SW)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .occupancy   (occupancy),
      .stall_clr   (stall_clr),
      .stall_count (stall_count)
   );

   pipe_skid_reg #(.N(N), .STALL_W(SW2)) u_dut_sat (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready2),
      .in_data     (in_data),
      .out_valid   (out_valid2),
      .out_ready   (out_ready),
      .out_data    (out_data2),
      .occupancy   (occupancy2),
      .stall_clr   (stall_clr),
      .stall_count (stall_count2)
   );

   typedef struct {
      logic        en;
      logic        fl;
      logic        iv;
      logic [31:0] id;
      logic        orr;
      logic        clr;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_od;
      logic        chk_od;
      logic [1:0]  e_occ;
      int          e_st;
   } vec_t;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [N-1:0] sb[$];
   vec_t         tbl[$];

   function automatic vec_t mk(input logic en, input logic fl, input logic iv,
                               input logic [31:0] id, input logic orr, input logic clr,
                               input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                               input logic chk_od, input logic [1:0] e_occ, input int e_st);
      vec_t v;
      v.en = en; v.fl = fl; v.iv = iv; v.id = id; v.orr = orr; v.clr = clr;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.chk_od = chk_od;
      v.e_occ = e_occ; v.e_st = e_st;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   // Drive one cycle of stimulus, check pre-edge outputs, then update the scoreboard.
   task automatic run_vec(input vec_t v, input string tag);
      int st2;
      @(posedge clk);
      #1;
      enable    = v.en;
      flush     = v.fl;
      in_valid  = v.iv;
      in_data   = v.id;
      out_ready = v.orr;
      stall_clr = v.clr;
      #1;
      st2 = (v.e_st > 3) ? 3 : v.e_st;
      chk({tag, " in_ready"},  32'(in_ready),     32'(v.e_ir));
      chk({tag, " out_valid"}, 32'(out_valid),    32'(v.e_ov));
      chk({tag, " occupancy"}, 32'(occupancy),    32'(v.e_occ));
      chk({tag, " stall"},     32'(stall_count),  32'(v.e_st));
      chk({tag, " stall_sat"}, 32'(stall_count2), 32'(st2));
      if (v.chk_od) chk({tag, " out_data"}, out_data, v.e_od);
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s sb: unexpected output %0h, want none", tag, out_data);
         end else begin
            chk({tag, " sb"}, out_data, sb.pop_front());
         end
      end
      if (v.fl) sb.delete();
      else if (v.iv && v.e_ir) sb.push_back(v.id);
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b0; stall_clr = 1'b0;

      //       en fl iv id      or clr  ir ov od     c occ st
      tbl.push_back(mk(1,0,1,32'h1 ,1,0, 1,0,32'h0 ,0,0,0));
      tbl.push_back(mk(1,0,1,32'h2 ,1,0, 1,1,32'h1 ,1,1,0));
      tbl.push_back(mk(1,0,1,32'h3 ,1,0, 1,1,32'h2 ,1,1,0));
      tbl.push_back(mk(1,0,0,32'h0 ,1,0, 1,1,32'h3 ,1,1,0));
      tbl.push_back(mk(1,0,1,32'hA ,0,0, 1,0,32'h0 ,0,0,0));
      tbl.push_back(mk(1,0,1,32'hB ,0,0, 1,1,32'hA ,1,1,0));
      tbl.push_back(mk(1,0,1,32'hC ,0,0, 0,1,32'hA ,1,2,1));
      tbl.push_back(mk(1,0,0,32'h0 ,1,0, 0,1,32'hA ,1,2,2));
      tbl.push_back(mk(1,0,0,32'h0 ,1,0, 1,1,32'hB ,1,1,2));
      tbl.push_back(mk(1,0,0,32'h0 ,1,0, 1,0,32'h0 ,0,0,2));
      tbl.push_back(mk(1,0,1,32'hD ,0,1, 1,0,32'h0 ,0,0,2));
      tbl.push_back(mk(1,0,1,32'hE ,0,1, 1,1,32'hD ,1,1,0));
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(1,0,0,32'h0,0,0, 0,1,32'hD,1,2,k));
      tbl.push_back(mk(1,0,0,32'h0 ,0,1, 0,1,32'hD ,1,2,5));
      tbl.push_back(mk(1,1,1,32'hF ,1,0, 0,1,32'hD ,1,2,0));
      tbl.push_back(mk(1,0,0,32'h0 ,1,0, 1,0,32'h0 ,0,0,0));
      tbl.push_back(mk(1,0,1,32'h11,0,0, 1,0,32'h0 ,0,0,0));
      tbl.push_back(mk(1,1,1,32'h22,1,0, 1,1,32'h11,1,1,0));
      tbl.push_back(mk(1,0,0,32'h0 ,1,0, 1,0,32'h0 ,0,0,0));
      tbl.push_back(mk(1,0,1,32'h55,0,0, 1,0,32'h0 ,0,0,0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(0,0,1,32'h66,1,0, 0,0,32'h55,1,1,0));
      tbl.push_back(mk(1,0,0,32'h0 ,1,0, 1,1,32'h55,1,1,0));
      tbl.push_back(mk(1,0,0,32'h0 ,1,0, 1,0,32'h0 ,0,0,0));
      tbl.push_back(mk(1,0,1,32'h77,0,0, 1,0,32'h0 ,0,0,0));
      tbl.push_back(mk(0,1,0,32'h0 ,0,0, 0,0,32'h77,1,1,0));
      tbl.push_back(mk(1,0,0,32'h0 ,1,0, 1,0,32'h0 ,0,0,0));

      // Reset values, with enable low then high.
      #2;
      chk("rst in_ready en0", 32'(in_ready),    32'h0);
      chk("rst out_valid",    32'(out_valid),   32'h0);
      chk("rst out_data",     out_data,         32'h0);
      chk("rst occupancy",    32'(occupancy),   32'h0);
      chk("rst stall",        32'(stall_count), 32'h0);
      enable = 1'b1;
      #1;
      chk("rst in_ready en1", 32'(in_ready),    32'h1);
      chk("rst out_valid en1", 32'(out_valid),  32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         run_vec(tbl[i], $sformatf("r%0d", i));

      // Fill to FULL, then assert reset asynchronously between edges.
      run_vec(mk(1,0,1,32'h101,0,0, 1,0,32'h0  ,0,0,0), "h0");
      run_vec(mk(1,0,1,32'h102,0,0, 1,1,32'h101,1,1,0), "h1");
      run_vec(mk(1,0,0,32'h0  ,0,0, 0,1,32'h101,1,2,1), "h2");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arst in_ready",  32'(in_ready),     32'h1);
      chk("arst out_valid", 32'(out_valid),    32'h0);
      chk("arst out_data",  out_data,          32'h0);
      chk("arst occupancy", 32'(occupancy),    32'h0);
      chk("arst stall",     32'(stall_count),  32'h0);
      chk("arst stall_sat", 32'(stall_count2), 32'h0);
      sb.delete();
      #2;
      rst = 1'b1;
      run_vec(mk(1,0,1,32'h201,1,0, 1,0,32'h0  ,0,0,0), "h3");
      run_vec(mk(1,0,0,32'h0  ,1,0, 1,1,32'h201,1,1,0), "h4");
      run_vec(mk(1,0,0,32'h0  ,1,0, 1,0,32'h0  ,0,0,0), "h5");

      chk("sb drained", 32'(sb.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pipe_skid_reg
